mem_access_arbiter: RTL and testbench

Multicycle controller that shares the single-ported 32 x 64-bit main memory between the instruction-fetch requester and the load/store requester. It accepts one request at a time over a valid/ready handshake and arbitrates round-robin between the two requesters. It sequences the memory's `sup`/`MemRead`/`MemWrite` strobes for exactly one access cycle, then returns load data or a store acknowledgement as a one-cycle response pulse. It sits between the core's fetch/LS stages and the main memory, and is the only block that drives the memory's control inputs.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_pick2.sv | 25 ++
 rtl/mem_access_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_access_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the IF/LS memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [2:0] SUP_MEM  = 3'b011;
  localparam logic [2:0] SUP_NONE = 3'b000;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int MEM_DEPTH = 32;
  localparam int MEM_AW    = 5;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2 : combinational 2-way round-robin pick, one-hot grant
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // bit 0 is the IF requester, bit 1 the LS requester
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == OWN_LS) ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter : multicycle IF/LS arbiter for the single-port main memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = MEM_AW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [63:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [63:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        ls_req_valid,
  input  logic        ls_req_we,
  input  logic [63:0] ls_req_addr,
  input  logic [63:0] ls_req_wdata,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [63:0] ls_rsp_data,
  output logic        ls_rsp_err,
  output logic [2:0]  mem_sup,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_load_addr,
  output logic [63:0] mem_store_addr,
  output logic [63:0] mem_store_data,
  input  logic [63:0] mem_load_data
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          last_grant_q, last_grant_d;

  logic [1:0]    gnt;
  logic          in_idle;
  logic          in_issue;
  logic          in_resp;
  logic          if_fire;
  logic          ls_fire;
  logic [63:0]   acc_addr;

  rr_pick2 u_pick (
    .req        ({ls_req_valid, if_req_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign in_idle  = (state_q == IDLE);
  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  assign if_req_ready = in_idle & gnt[0] & if_req_valid & rst_n;
  assign ls_req_ready = in_idle & gnt[1] & ls_req_valid & rst_n;
  assign if_fire      = if_req_valid & if_req_ready;
  assign ls_fire      = ls_req_valid & ls_req_ready;
  assign acc_addr     = ls_fire ? ls_req_addr : if_req_addr;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (if_fire || ls_fire) begin
          owner_d      = ls_fire ? OWN_LS : OWN_IF;
          last_grant_d = ls_fire ? OWN_LS : OWN_IF;
          we_d         = ls_fire & ls_req_we;
          addr_d       = acc_addr[AW-1:0];
          wdata_d      = ls_fire ? ls_req_wdata : 64'd0;
          data_d       = 64'd0;
          // the low-index test only matters for a non power-of-two DEPTH
          err_d        = (|acc_addr[63:AW]) ||
                         (32'(acc_addr[AW-1:0]) >= 32'(DEPTH));
          state_d      = err_d ? RESP : ISSUE;
        end
      end
      ISSUE:   state_d = we_q ? RESP : CAPTURE;
      CAPTURE: begin
        data_d  = mem_load_data;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 64'd0;
      data_q       <= 64'd0;
      err_q        <= 1'b0;
      last_grant_q <= OWN_LS;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  // strobes come from the state flop alone, so an async reset kills them at once
  assign mem_sup        = in_issue ? SUP_MEM : SUP_NONE;
  assign mem_read       = in_issue & ~we_q;
  assign mem_write      = in_issue & we_q;
  assign mem_load_addr  = {{(64-AW){1'b0}}, addr_q};
  assign mem_store_addr = {{(64-AW){1'b0}}, addr_q};
  assign mem_store_data = wdata_q;

  assign if_rsp_valid = in_resp & (owner_q == OWN_IF);
  assign ls_rsp_valid = in_resp & (owner_q == OWN_LS);
  assign if_rsp_data  = if_rsp_valid ? data_q : 64'd0;
  assign ls_rsp_data  = ls_rsp_valid ? data_q : 64'd0;
  assign if_rsp_err   = if_rsp_valid & err_q;
  assign ls_rsp_err   = ls_rsp_valid & err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_access_arbiter : directed vectors plus reset/contention sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [63:0] if_req_addr = 64'd0;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        if_rsp_err;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_we = 1'b0;
  logic [63:0] ls_req_addr = 64'd0;
  logic [63:0] ls_req_wdata = 64'd0;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_data;
  logic        ls_rsp_err;
  logic [2:0]  mem_sup;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_load_addr;
  logic [63:0] mem_store_addr;
  logic [63:0] mem_store_data;
  logic [63:0] mem_load_data = 64'd0;

  logic        init_mem = 1'b1;
  logic [63:0] mem [32];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_data    (if_rsp_data),
    .if_rsp_err     (if_rsp_err),
    .ls_req_valid   (ls_req_valid),
    .ls_req_we      (ls_req_we),
    .ls_req_addr    (ls_req_addr),
    .ls_req_wdata   (ls_req_wdata),
    .ls_req_ready   (ls_req_ready),
    .ls_rsp_valid   (ls_rsp_valid),
    .ls_rsp_data    (ls_rsp_data),
    .ls_rsp_err     (ls_rsp_err),
    .mem_sup        (mem_sup),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_load_addr  (mem_load_addr),
    .mem_store_addr (mem_store_addr),
    .mem_store_data (mem_store_data),
    .mem_load_data  (mem_load_data)
  );

  // main-memory model: initial contents 1111_0000_0000_00ii, registered read
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'h1111_0000_0000_0000 + 64'(i);
    end else if (mem_sup == 3'b011) begin
      if (mem_write) mem[mem_store_addr[4:0]] <= mem_store_data;
      if (mem_read)  mem_load_data <= mem[mem_load_addr[4:0]];
    end
  end

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_iss;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_req(input string tag, input vec_t v);
    int          iss = 0;
    int          rsp_cyc = -1;
    logic [63:0] rdata = 64'd0;
    logic        rerr = 1'b0;
    logic        other = 1'b0;
    logic        strobe_ok = 1'b1;
    @(posedge clk); #1;
    if (v.is_ls) begin
      ls_req_valid = 1'b1; ls_req_we = v.we; ls_req_addr = v.addr; ls_req_wdata = v.wdata;
    end else begin
      if_req_valid = 1'b1; if_req_addr = v.addr;
    end
    #1;
    chk({tag, " ready"}, 64'(v.is_ls ? ls_req_ready : if_req_ready), 64'd1);
    for (int c = 1; c <= 8 && rsp_cyc < 0; c++) begin
      @(posedge clk); #1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      #1;
      if (mem_sup == 3'b011) begin
        iss++;
        if (mem_write !== v.we || mem_read !== !v.we || c != 1) strobe_ok = 1'b0;
        if (v.we && (mem_store_addr !== v.addr || mem_store_data !== v.wdata)) strobe_ok = 1'b0;
        if (!v.we && mem_load_addr !== v.addr) strobe_ok = 1'b0;
      end else if (mem_sup !== 3'b000 || mem_read || mem_write) begin
        strobe_ok = 1'b0;
      end
      if (v.is_ls ? if_rsp_valid : ls_rsp_valid) other = 1'b1;
      if (v.is_ls ? ls_rsp_valid : if_rsp_valid) begin
        rsp_cyc = c;
        rdata = v.is_ls ? ls_rsp_data : if_rsp_data;
        rerr  = v.is_ls ? ls_rsp_err  : if_rsp_err;
      end
    end
    chk({tag, " rsp_cycle"}, 64'(rsp_cyc), 64'(v.exp_lat));
    chk({tag, " rsp_data"}, rdata, v.exp_data);
    chk({tag, " rsp_err"}, 64'(rerr), 64'(v.exp_err));
    chk({tag, " issue_count"}, 64'(iss), 64'(v.exp_iss));
    chk({tag, " strobes"}, 64'(strobe_ok), 64'd1);
    chk({tag, " other_port_quiet"}, 64'(other), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g_cyc  [4];
    logic        g_who  [4];
    int          r_cyc  [4];
    logic [63:0] r_dat  [4];
    int          ng = 0;
    int          nr = 0;
    int          dbl = 0;
    logic        prev_iss = 1'b0;
    logic        seen = 1'b0;
    vec_t        v;

    vecs[0] = '{1'b1, 1'b1, 64'd5,  64'hDEAD_BEEF_0000_0001, 64'd0,                   1'b0, 2, 1};
    vecs[1] = '{1'b1, 1'b0, 64'd5,  64'd0,                   64'hDEAD_BEEF_0000_0001, 1'b0, 3, 1};
    vecs[2] = '{1'b0, 1'b0, 64'd5,  64'd0,                   64'hDEAD_BEEF_0000_0001, 1'b0, 3, 1};
    vecs[3] = '{1'b0, 1'b0, 64'd0,  64'd0,                   64'h1111_0000_0000_0000, 1'b0, 3, 1};
    vecs[4] = '{1'b1, 1'b1, 64'd31, 64'h0123_4567_89AB_CDEF, 64'd0,                   1'b0, 2, 1};
    vecs[5] = '{1'b1, 1'b0, 64'd31, 64'd0,                   64'h0123_4567_89AB_CDEF, 1'b0, 3, 1};
    vecs[6] = '{1'b1, 1'b0, 64'd32, 64'd0,                   64'd0,                   1'b1, 1, 0};
    vecs[7] = '{1'b0, 1'b0, 64'h1_0000_0000, 64'd0,          64'd0,                   1'b1, 1, 0};
    vecs[8] = '{1'b1, 1'b1, 64'd32, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1'b1, 1, 0};
    vecs[9] = '{1'b1, 1'b0, 64'd0,  64'd0,                   64'h1111_0000_0000_0000, 1'b0, 3, 1};

    // reset held with both requesters valid
    if_req_valid = 1'b1; if_req_addr = 64'd0;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 64'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", 64'(|{if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
                               ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
                               mem_sup, mem_read, mem_write, mem_load_addr,
                               mem_store_addr, mem_store_data}), 64'd0);
    chk("reset ready", 64'({if_req_ready, ls_req_ready}), 64'd0);
    init_mem = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("first tie if_ready", 64'(if_req_ready), 64'd1);
    chk("first tie ls_ready", 64'(ls_req_ready), 64'd0);
    @(posedge clk); #1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 10; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // both requesters continuously valid for 16 cycles
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'd2;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 64'd7;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #1;
      if ((if_req_ready || ls_req_ready) && ng < 4) begin
        g_cyc[ng] = c; g_who[ng] = ls_req_ready; ng++;
      end
      if (if_req_ready && ls_req_ready) dbl++;
      if ((if_rsp_valid || ls_rsp_valid) && nr < 4) begin
        r_cyc[nr] = c; r_dat[nr] = if_rsp_valid ? if_rsp_data : ls_rsp_data; nr++;
      end
      if (mem_sup == 3'b011 && prev_iss) dbl++;
      prev_iss = (mem_sup == 3'b011);
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    chk("contention grants", 64'(ng), 64'd4);
    chk("contention responses", 64'(nr), 64'd4);
    chk("contention overlap", 64'(dbl), 64'd0);
    for (int k = 0; k < 4 && k < ng; k++) begin
      chk($sformatf("grant%0d cycle", k), 64'(g_cyc[k]), 64'(4 * k));
      chk($sformatf("grant%0d owner", k), 64'(g_who[k]), 64'(k % 2));
    end
    for (int k = 0; k < 4 && k < nr; k++) begin
      chk($sformatf("resp%0d cycle", k), 64'(r_cyc[k]), 64'(4 * k + 3));
      chk($sformatf("resp%0d data", k), r_dat[k],
          (k % 2 == 0) ? 64'h1111_0000_0000_0002 : 64'h1111_0000_0000_0007);
    end

    // reset asserted during the ISSUE cycle of a store to index 9
    @(posedge clk); #1;
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 64'd9;
    ls_req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    chk("abort ready", 64'(ls_req_ready), 64'd1);
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    #1;
    chk("abort issue write", 64'(mem_write), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort strobes", 64'({mem_sup, mem_read, mem_write}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      if (ls_rsp_valid || if_rsp_valid) seen = 1'b1;
    end
    chk("abort rsp dropped", 64'(seen), 64'd0);
    v = '{1'b1, 1'b0, 64'd9, 64'd0, 64'h1111_0000_0000_0009, 1'b0, 3, 1};
    run_req("abort reload", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
